// File: rtl/imem_fetch_ctrl_if.sv
// Bundle of the loader handshake, instruction-memory port and fetch-stage
// outputs of imem_fetch_ctrl.
//   master : the fetch controller (drives ld_ready, mem_*, if_*)
//   slave  : the environment (loader, instruction memory, decode stage)
// Signals:
//   ld_valid/ld_ready/ld_data/ld_last : program loader stream
//   mem_addr/mem_we/mem_wdata         : instruction memory write/read port
//   mem_rdata                         : combinational read data
//   if_valid/if_pc/if_instr           : fetched instruction to decode
interface imem_fetch_ctrl_if;
  logic        ld_valid;
  logic        ld_ready;
  logic [31:0] ld_data;
  logic        ld_last;
  logic [5:0]  mem_addr;
  logic        mem_we;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        if_valid;
  logic [7:0]  if_pc;
  logic [31:0] if_instr;

  modport master (
    input  ld_valid, ld_data, ld_last, mem_rdata,
    output ld_ready, mem_addr, mem_we, mem_wdata, if_valid, if_pc, if_instr
  );

  modport slave (
    output ld_valid, ld_data, ld_last, mem_rdata,
    input  ld_ready, mem_addr, mem_we, mem_wdata, if_valid, if_pc, if_instr
  );
endinterface

// File: rtl/imem_fetch_ctrl.sv
// Instruction memory fetch controller.
// LOAD: streams loader words into instruction memory at wr_ptr. The last
//       word (ld_last) or filling all DEPTH words moves to RUN; filling
//       without ld_last flags err_overflow.
// RUN : fetches one word per cycle from pc, honouring cpu_stall, branch
//       redirects (one NOP bubble) and reload back to LOAD.
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   reload       : return to LOAD from RUN
//   cpu_stall    : hold fetch stage
//   br_taken     : redirect fetch to br_target (word aligned)
//   br_target    : redirect byte address
//   load_done    : registered, high while in RUN
//   err_overflow : sticky, program exceeded DEPTH words
//   bus          : loader / memory / fetch signals (imem_fetch_ctrl_if)
module imem_fetch_ctrl #(
  parameter int unsigned DEPTH    = 64,
  parameter logic [7:0]  RESET_PC = 8'h00,
  parameter logic [31:0] NOP      = 32'h00000033
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             reload,
  input  logic             cpu_stall,
  input  logic             br_taken,
  input  logic [7:0]       br_target,
  output logic             load_done,
  output logic             err_overflow,
  imem_fetch_ctrl_if.master bus
);

  typedef enum logic {
    LOAD,
    RUN
  } state_t;

  localparam logic [5:0] LAST_ADDR = 6'(DEPTH - 1);

  state_t      state_q, state_d;
  logic [5:0]  wr_ptr_q, wr_ptr_d;
  logic [7:0]  pc_q, pc_d;
  logic        if_valid_q, if_valid_d;
  logic [7:0]  if_pc_q, if_pc_d;
  logic [31:0] if_instr_q, if_instr_d;
  logic        load_done_q, load_done_d;
  logic        err_q, err_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= LOAD;
      wr_ptr_q    <= '0;
      pc_q        <= RESET_PC;
      if_valid_q  <= 1'b0;
      if_pc_q     <= '0;
      if_instr_q  <= NOP;
      load_done_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      pc_q        <= pc_d;
      if_valid_q  <= if_valid_d;
      if_pc_q     <= if_pc_d;
      if_instr_q  <= if_instr_d;
      load_done_q <= load_done_d;
      err_q       <= err_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    wr_ptr_d      = wr_ptr_q;
    pc_d          = pc_q;
    if_valid_d    = if_valid_q;
    if_pc_d       = if_pc_q;
    if_instr_d    = if_instr_q;
    load_done_d   = load_done_q;
    err_d         = err_q;
    bus.ld_ready  = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = pc_q[7:2];
    bus.mem_wdata = bus.ld_data;

    case (state_q)
      LOAD: begin
        bus.ld_ready = 1'b1;
        bus.mem_addr = wr_ptr_q;
        bus.mem_we   = bus.ld_valid;
        if (bus.ld_valid) begin
          // ld_last on the final slot is a clean finish, not an overflow
          if (bus.ld_last || wr_ptr_q == LAST_ADDR) begin
            state_d     = RUN;
            wr_ptr_d    = '0;
            pc_d        = RESET_PC;
            load_done_d = 1'b1;
            if (!bus.ld_last) err_d = 1'b1;
          end else begin
            wr_ptr_d = wr_ptr_q + 6'd1;
          end
        end
      end
      RUN: begin
        // priority: reload > br_taken > cpu_stall > normal fetch
        if (reload) begin
          state_d     = LOAD;
          wr_ptr_d    = '0;
          if_valid_d  = 1'b0;
          if_instr_d  = NOP;
          load_done_d = 1'b0;
          err_d       = 1'b0;
        end else if (br_taken) begin
          pc_d       = br_target & 8'hFC;
          if_valid_d = 1'b0;
          if_instr_d = NOP;
        end else if (!cpu_stall) begin
          if_instr_d = bus.mem_rdata;
          if_pc_d    = pc_q;
          if_valid_d = 1'b1;
          pc_d       = pc_q + 8'd4;
        end
      end
      default: state_d = LOAD;
    endcase
  end

  assign bus.if_valid  = if_valid_q;
  assign bus.if_pc     = if_pc_q;
  assign bus.if_instr  = if_instr_q;
  assign load_done     = load_done_q;
  assign err_overflow  = err_q;

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Directed bench for imem_fetch_ctrl with a behavioural instruction memory
// and a log of every write address seen on the memory port.
module tb_imem_fetch_ctrl;
  localparam logic [31:0] NOP = 32'h00000033;

  logic       clk = 1'b0;
  logic       rst;
  logic       reload, cpu_stall, br_taken;
  logic [7:0] br_target;
  logic       load_done, err_overflow;

  int errors = 0;
  int checks = 0;

  logic [31:0] mem [0:63];
  logic [5:0]  wr_log [$];
  logic [31:0] exp_w;

  imem_fetch_ctrl_if bus ();

  imem_fetch_ctrl #(.DEPTH(64), .RESET_PC(8'h00), .NOP(NOP)) dut (
    .clk(clk), .rst(rst), .reload(reload), .cpu_stall(cpu_stall),
    .br_taken(br_taken), .br_target(br_target), .load_done(load_done),
    .err_overflow(err_overflow), .bus(bus)
  );

  always #5 clk = ~clk;

  assign bus.mem_rdata = mem[bus.mem_addr];

  always @(posedge clk) begin
    if (!rst && bus.mem_we) begin
      mem[bus.mem_addr] <= bus.mem_wdata;
      wr_log.push_back(bus.mem_addr);
    end
  end

  task automatic clear_inputs();
    reload = 0; cpu_stall = 0; br_taken = 0; br_target = 8'h00;
    bus.ld_valid = 0; bus.ld_data = '0; bus.ld_last = 0;
  endtask

  task automatic do_reset();
    rst = 1; clear_inputs();
    repeat (2) @(posedge clk);
    #1 rst = 0;
    wr_log.delete();
  endtask

  task automatic test_reset();
    rst = 1; clear_inputs();
    #1;
    checks++; if (bus.ld_ready !== 1'b1) begin errors++; $display("FAIL reset_ld_ready: got %b want 1", bus.ld_ready); end
    checks++; if (bus.if_valid !== 1'b0) begin errors++; $display("FAIL reset_if_valid: got %b want 0", bus.if_valid); end
    checks++; if (bus.if_pc !== 8'h00) begin errors++; $display("FAIL reset_if_pc: got %h want 00", bus.if_pc); end
    checks++; if (bus.if_instr !== NOP) begin errors++; $display("FAIL reset_if_instr: got %h want %h", bus.if_instr, NOP); end
    checks++; if (load_done !== 1'b0) begin errors++; $display("FAIL reset_load_done: got %b want 0", load_done); end
    checks++; if (err_overflow !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", err_overflow); end
    checks++; if (bus.mem_addr !== 6'd0) begin errors++; $display("FAIL reset_mem_addr: got %0d want 0", bus.mem_addr); end
    do_reset();
  endtask

  // 13-word load, then first four fetches (if_pc 0x00..0x0C)
  task automatic test_load_run();
    for (int i = 0; i < 13; i++) begin
      bus.ld_valid = 1; bus.ld_data = 32'h1000_0000 + 32'(i); bus.ld_last = (i == 12);
      #1;
      checks++; if (bus.mem_we !== 1'b1 || bus.mem_addr !== 6'(i)) begin errors++; $display("FAIL load_write[%0d]: we=%b addr=%0d want we=1 addr=%0d", i, bus.mem_we, bus.mem_addr, i); end
      if (i == 12) begin
        checks++; if (load_done !== 1'b0) begin errors++; $display("FAIL load_done_early: got %b want 0", load_done); end
      end
      @(posedge clk); #1;
    end
    bus.ld_valid = 0; bus.ld_last = 0;
    #1;
    checks++; if (load_done !== 1'b1) begin errors++; $display("FAIL load_done_set: got %b want 1", load_done); end
    checks++; if (bus.if_valid !== 1'b0) begin errors++; $display("FAIL run_first_latency: if_valid got %b want 0", bus.if_valid); end
    checks++; if (bus.ld_ready !== 1'b0 || bus.mem_we !== 1'b0) begin errors++; $display("FAIL run_ld_ready_we: got %b/%b want 0/0", bus.ld_ready, bus.mem_we); end
    checks++; if (wr_log.size() !== 13) begin errors++; $display("FAIL load_write_count: got %0d want 13", wr_log.size()); end
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      exp_w = 32'h1000_0000 + 32'(k);
      checks++; if (bus.if_valid !== 1'b1 || bus.if_pc !== 8'(4 * k) || bus.if_instr !== exp_w) begin errors++; $display("FAIL fetch[%0d]: v=%b pc=%h instr=%h want v=1 pc=%h instr=%h", k, bus.if_valid, bus.if_pc, bus.if_instr, 8'(4 * k), exp_w); end
    end
  endtask

  // stall four cycles at if_pc 0x0C, then resume at 0x10
  task automatic test_stall();
    cpu_stall = 1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      checks++; if (bus.if_valid !== 1'b1 || bus.if_pc !== 8'h0C || bus.if_instr !== 32'h1000_0003) begin errors++; $display("FAIL stall_hold[%0d]: v=%b pc=%h instr=%h want v=1 pc=0c instr=10000003", k, bus.if_valid, bus.if_pc, bus.if_instr); end
    end
    checks++; if (bus.mem_addr !== 6'd4) begin errors++; $display("FAIL stall_pc_addr: got %0d want 4", bus.mem_addr); end
    cpu_stall = 0;
    @(posedge clk); #1;
    checks++; if (bus.if_pc !== 8'h10 || bus.if_instr !== 32'h1000_0004) begin errors++; $display("FAIL stall_resume: pc=%h instr=%h want pc=10 instr=10000004", bus.if_pc, bus.if_instr); end
  endtask

  // branch to 0x23 while stalled: one NOP bubble, then fetch at 0x20
  task automatic test_branch();
    cpu_stall = 1; br_taken = 1; br_target = 8'h23;
    @(posedge clk); #1;
    cpu_stall = 0; br_taken = 0;
    checks++; if (bus.if_valid !== 1'b0 || bus.if_instr !== NOP || bus.if_pc !== 8'h10) begin errors++; $display("FAIL branch_bubble: v=%b instr=%h pc=%h want v=0 instr=%h pc=10", bus.if_valid, bus.if_instr, bus.if_pc, NOP); end
    @(posedge clk); #1;
    checks++; if (bus.if_valid !== 1'b1 || bus.if_pc !== 8'h20 || bus.if_instr !== 32'h1000_0008) begin errors++; $display("FAIL branch_target: v=%b pc=%h instr=%h want v=1 pc=20 instr=10000008", bus.if_valid, bus.if_pc, bus.if_instr); end
  endtask

  // 65 words, no ld_last: 64 writes, overflow, then pc wrap 0xFC -> 0x00
  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < 64; i++) begin
      bus.ld_valid = 1; bus.ld_data = 32'h2000_0000 + 32'(i); bus.ld_last = 0;
      @(posedge clk); #1;
    end
    bus.ld_data = 32'h2000_0040;
    #1;
    checks++; if (err_overflow !== 1'b1) begin errors++; $display("FAIL ovf_err: got %b want 1", err_overflow); end
    checks++; if (load_done !== 1'b1) begin errors++; $display("FAIL ovf_load_done: got %b want 1", load_done); end
    checks++; if (bus.mem_we !== 1'b0 || bus.ld_ready !== 1'b0) begin errors++; $display("FAIL ovf_65th_ignored: we=%b rdy=%b want 0/0", bus.mem_we, bus.ld_ready); end
    checks++; if (wr_log.size() !== 64) begin errors++; $display("FAIL ovf_write_count: got %0d want 64", wr_log.size()); end
    checks++; if (wr_log[63] !== 6'd63) begin errors++; $display("FAIL ovf_last_addr: got %0d want 63", wr_log[63]); end
    @(posedge clk); #1;
    bus.ld_valid = 0;
    checks++; if (wr_log.size() !== 64) begin errors++; $display("FAIL ovf_no_extra_write: got %0d want 64", wr_log.size()); end
    checks++; if (bus.if_pc !== 8'h00 || bus.if_instr !== 32'h2000_0000) begin errors++; $display("FAIL ovf_first_fetch: pc=%h instr=%h want 00/20000000", bus.if_pc, bus.if_instr); end
    repeat (63) @(posedge clk);
    #1;
    checks++; if (bus.if_pc !== 8'hFC || bus.if_instr !== 32'h2000_003F) begin errors++; $display("FAIL wrap_fc: pc=%h instr=%h want fc/2000003f", bus.if_pc, bus.if_instr); end
    @(posedge clk); #1;
    checks++; if (bus.if_pc !== 8'h00 || bus.if_instr !== 32'h2000_0000) begin errors++; $display("FAIL wrap_00: pc=%h instr=%h want 00/20000000", bus.if_pc, bus.if_instr); end
  endtask

  // reload + br_taken + stall together: reload wins, err cleared
  task automatic test_reload_branch();
    reload = 1; br_taken = 1; br_target = 8'h40; cpu_stall = 1;
    @(posedge clk); #1;
    reload = 0; br_taken = 0; cpu_stall = 0;
    checks++; if (bus.ld_ready !== 1'b1) begin errors++; $display("FAIL reload_ld_ready: got %b want 1", bus.ld_ready); end
    checks++; if (bus.if_valid !== 1'b0 || bus.if_instr !== NOP) begin errors++; $display("FAIL reload_if: v=%b instr=%h want 0/%h", bus.if_valid, bus.if_instr, NOP); end
    checks++; if (err_overflow !== 1'b0 || load_done !== 1'b0) begin errors++; $display("FAIL reload_flags: err=%b done=%b want 0/0", err_overflow, load_done); end
    checks++; if (bus.mem_addr !== 6'd0) begin errors++; $display("FAIL reload_wr_ptr: got %0d want 0", bus.mem_addr); end
  endtask

  // 5 words (reload ignored in LOAD), rst mid-load, restart at word 0
  task automatic test_rst_midload();
    wr_log.delete();
    for (int i = 0; i < 5; i++) begin
      bus.ld_valid = 1; bus.ld_data = 32'h3000_0000 + 32'(i); bus.ld_last = 0; reload = (i == 2);
      @(posedge clk); #1;
    end
    bus.ld_valid = 0; reload = 0;
    checks++; if (wr_log.size() !== 5 || wr_log[4] !== 6'd4) begin errors++; $display("FAIL midload_progress: n=%0d last=%0d want 5/4", wr_log.size(), wr_log[4]); end
    rst = 1; #2;
    checks++; if (bus.mem_addr !== 6'd0 || bus.ld_ready !== 1'b1) begin errors++; $display("FAIL midload_rst: addr=%0d rdy=%b want 0/1", bus.mem_addr, bus.ld_ready); end
    rst = 0;
    bus.ld_valid = 1; bus.ld_data = 32'h4000_0000; bus.ld_last = 1;
    @(posedge clk); #1;
    bus.ld_valid = 0; bus.ld_last = 0;
    checks++; if (wr_log.size() !== 6 || wr_log[5] !== 6'd0) begin errors++; $display("FAIL midload_restart: n=%0d addr=%0d want 6/0", wr_log.size(), wr_log[5]); end
    checks++; if (load_done !== 1'b1) begin errors++; $display("FAIL midload_done: got %b want 1", load_done); end
  endtask

  // rst during RUN drops if_valid immediately
  task automatic test_rst_midrun();
    @(posedge clk); #1;
    checks++; if (bus.if_valid !== 1'b1 || bus.if_instr !== 32'h4000_0000) begin errors++; $display("FAIL midrun_fetch: v=%b instr=%h want 1/40000000", bus.if_valid, bus.if_instr); end
    rst = 1; #1;
    checks++; if (bus.if_valid !== 1'b0 || bus.ld_ready !== 1'b1 || load_done !== 1'b0) begin errors++; $display("FAIL midrun_rst: v=%b rdy=%b done=%b want 0/1/0", bus.if_valid, bus.ld_ready, load_done); end
    rst = 0;
  endtask

  // one word every third cycle: exactly three writes at 0,1,2
  task automatic test_gapped();
    do_reset();
    for (int w = 0; w < 3; w++) begin
      bus.ld_valid = 1; bus.ld_data = 32'h5000_0000 + 32'(w); bus.ld_last = (w == 2);
      @(posedge clk); #1;
      bus.ld_valid = 0; bus.ld_last = 0;
      if (w < 2) begin
        repeat (2) begin @(posedge clk); #1; end
      end
    end
    checks++; if (wr_log.size() !== 3) begin errors++; $display("FAIL gapped_count: got %0d want 3", wr_log.size()); end
    for (int w = 0; w < 3; w++) begin
      checks++; if (wr_log[w] !== 6'(w)) begin errors++; $display("FAIL gapped_addr[%0d]: got %0d want %0d", w, wr_log[w], w); end
    end
    checks++; if (load_done !== 1'b1) begin errors++; $display("FAIL gapped_done: got %b want 1", load_done); end
    @(posedge clk); #1;
    checks++; if (bus.if_pc !== 8'h00 || bus.if_instr !== 32'h5000_0000) begin errors++; $display("FAIL gapped_fetch: pc=%h instr=%h want 00/50000000", bus.if_pc, bus.if_instr); end
  endtask

  initial begin
    test_reset();
    test_load_run();
    test_stall();
    test_branch();
    test_overflow();
    test_reload_branch();
    test_rst_midload();
    test_rst_midrun();
    test_gapped();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
